// File: rtl/portal_msg_deframer.sv
// Portal request deframer: parses header+payload beat streams from the message sink
// into tagged payload words, buffered in a small FIFO with a valid/ready output.
module portal_msg_deframer #(
  parameter int METHOD_W    = 6,
  parameter int NUM_METHODS = 16,
  parameter int MAX_WORDS   = 64,
  parameter int DEPTH       = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_rdy,
  output logic                in_en,
  input  logic [31:0]         in_beat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic [METHOD_W-1:0] out_method,
  output logic                out_first,
  output logic                out_last,
  output logic                err_pulse,
  output logic [15:0]         msg_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

  typedef struct packed {
    logic [METHOD_W-1:0] method;
    logic [31:0]         data;
    logic                first;
    logic                last;
  } entry_t;

  state_t              r_state;
  logic [15:0]         r_remain;
  logic [METHOD_W-1:0] r_method;
  logic                r_first_flag;
  logic                r_err;
  logic [15:0]         r_msg_count;

  entry_t              r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_full;
  logic                w_empty;
  logic [15:0]         w_hdr_id;
  logic [15:0]         w_hdr_len;
  logic                w_hdr_bad;
  logic                w_push;
  logic                w_pop;
  entry_t              w_push_entry;
  entry_t              w_head;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_hdr_id  = in_beat[31:16];
  assign w_hdr_len = in_beat[15:0];
  assign w_hdr_bad = (w_hdr_id >= 16'(NUM_METHODS)) || (w_hdr_len > 16'(MAX_WORDS));

  // DROP drains the stream regardless of FIFO space since nothing is queued there.
  assign in_en = !RST && in_rdy && ((r_state == S_DROP) || !w_full);
  assign w_pop = !w_empty && out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '0;
    if (in_en) begin
      case (r_state)
        S_HDR: begin
          if (w_hdr_len == 16'd1 && !w_hdr_bad) begin
            w_push       = 1'b1;
            w_push_entry = '{method: w_hdr_id[METHOD_W-1:0], data: 32'h0, first: 1'b1, last: 1'b1};
          end
        end
        S_PAY: begin
          w_push       = 1'b1;
          w_push_entry = '{method: r_method, data: in_beat, first: r_first_flag,
                           last: (r_remain == 16'd1)};
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_HDR;
      r_remain     <= '0;
      r_method     <= '0;
      r_first_flag <= 1'b0;
      r_err        <= 1'b0;
      r_msg_count  <= '0;
    end else begin
      r_err <= 1'b0;
      if (in_en) begin
        case (r_state)
          S_HDR: begin
            if (w_hdr_len == 16'd0) begin
              r_err <= 1'b1;
            end else if (w_hdr_bad) begin
              r_err <= 1'b1;
              if (w_hdr_len > 16'd1) begin
                r_remain <= w_hdr_len - 16'd1;
                r_state  <= S_DROP;
              end
            end else if (w_hdr_len == 16'd1) begin
              r_msg_count <= r_msg_count + 16'd1;
            end else begin
              r_method     <= w_hdr_id[METHOD_W-1:0];
              r_remain     <= w_hdr_len - 16'd1;
              r_first_flag <= 1'b1;
              r_state      <= S_PAY;
            end
          end
          S_PAY: begin
            r_first_flag <= 1'b0;
            r_remain     <= r_remain - 16'd1;
            if (r_remain == 16'd1) begin
              r_msg_count <= r_msg_count + 16'd1;
              r_state     <= S_HDR;
            end
          end
          S_DROP: begin
            r_remain <= r_remain - 16'd1;
            if (r_remain == 16'd1) r_state <= S_HDR;
          end
          default: r_state <= S_HDR;
        endcase
      end
    end
  end

  // NOTE: the small FIFO storage is reset so the presented head reads as all-zero after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = !w_empty;
  assign out_data   = w_head.data;
  assign out_method = w_head.method;
  assign out_first  = w_head.first;
  assign out_last   = w_head.last;
  assign err_pulse  = r_err;
  assign msg_count  = r_msg_count;

endmodule

// File: tb/tb_portal_msg_deframer.sv
// Scoreboard bench for portal_msg_deframer: message-level reference model feeds an
// expected-word queue; a negedge monitor pops and compares every accepted output word.
module tb_portal_msg_deframer;

  localparam int METHOD_W    = 6;
  localparam int NUM_METHODS = 16;
  localparam int MAX_WORDS   = 64;
  localparam int DEPTH       = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic                in_rdy;
  logic                in_en;
  logic [31:0]         in_beat;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic [METHOD_W-1:0] out_method;
  logic                out_first;
  logic                out_last;
  logic                err_pulse;
  logic [15:0]         msg_count;

  portal_msg_deframer #(
    .METHOD_W(METHOD_W), .NUM_METHODS(NUM_METHODS), .MAX_WORDS(MAX_WORDS), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .in_rdy(in_rdy), .in_en(in_en), .in_beat(in_beat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_method(out_method), .out_first(out_first), .out_last(out_last),
    .err_pulse(err_pulse), .msg_count(msg_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [METHOD_W-1:0] method;
    logic [31:0]         data;
    logic                first;
    logic                last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp      = 0;
  int   n_fail     = 0;
  int   err_seen   = 0;
  int   exp_err    = 0;
  int   exp_msg    = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      out_ready = (ready_mode == 1) ? 1'b1 :
                  (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RST) begin
      if (err_pulse) err_seen++;
      if (in_en) check("inen_implies_rdy", 64'(in_rdy), 64'd1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got word %0h with nothing expected", out_data);
        end else begin
          e = sb.pop_front();
          check("out_word", 64'({out_method, out_data, out_first, out_last}), 64'(e));
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d);
    int t = 0;
    in_rdy  = 1'b1;
    in_beat = d;
    do begin
      @(negedge CLK);
      t++;
    end while (!in_en && t < 500);
    if (!in_en) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_timeout: in_en stayed 0 for beat %0h", d);
    end
    @(posedge CLK);
    #1;
    in_rdy  = 1'b0;
    in_beat = $urandom;
    repeat ($urandom_range(0, 1)) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Reference model: decides the fate of a whole message from its header fields.
  task automatic send_msg(input logic [15:0] id, input logic [15:0] len);
    logic [31:0] w;
    int          nbody;
    bit          bad;
    bad   = (len == 0) || (id >= NUM_METHODS) || (len > MAX_WORDS);
    nbody = (len == 0) ? 0 : int'(len) - 1;
    if (bad) exp_err++;
    else if (len == 1) begin
      sb.push_back('{method: id[METHOD_W-1:0], data: 32'h0, first: 1'b1, last: 1'b1});
      exp_msg++;
    end
    send_beat({id, len});
    for (int i = 0; i < nbody; i++) begin
      w = $urandom;
      if (!bad)
        sb.push_back('{method: id[METHOD_W-1:0], data: w, first: (i == 0), last: (i == nbody - 1)});
      send_beat(w);
    end
    if (!bad && len > 1) exp_msg++;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() > 0 && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    repeat (2) @(negedge CLK);
    check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_msg_count"}, 64'(msg_count), 64'(16'(exp_msg)));
    check({tag, "_err_count"}, 64'(err_seen), 64'(exp_err));
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ready(input int mode);
    ready_mode = mode;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] w [6];
    RST     = 1'b1;
    in_rdy  = 1'b0;
    in_beat = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_method", 64'(out_method), 64'd0);
    check("rst_out_first", 64'(out_first), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_err_pulse", 64'(err_pulse), 64'd0);
    check("rst_msg_count", 64'(msg_count), 64'd0);
    check("rst_in_en", 64'(in_en), 64'd0);
    @(posedge CLK);
    #1;

    send_msg(16'd3, 16'd3);
    drain("two_word");
    send_msg(16'd5, 16'd1);
    drain("hdr_only");
    send_msg(16'd20, 16'd4);
    send_msg(16'd1, 16'd2);
    drain("bad_id_drop");
    send_msg(16'd2, 16'd0);
    send_msg(16'd4, 16'd2);
    drain("zero_len");
    send_msg(16'd7, 16'd65);
    send_msg(16'd15, 16'd64);
    drain("len_limit");

    // Backpressure: six payload words into a four-entry FIFO with the sink stalled.
    set_ready(0);
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    send_beat({16'd9, 16'd7});
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{method: 6'd9, data: w[i], first: (i == 0), last: 1'b0});
      send_beat(w[i]);
    end
    in_rdy  = 1'b1;
    in_beat = w[4];
    repeat (3) @(negedge CLK);
    check("full_in_en", 64'(in_en), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge CLK);
    #1;
    ready_mode = 1;
    for (int i = 4; i < 6; i++) begin
      sb.push_back('{method: 6'd9, data: w[i], first: 1'b0, last: (i == 5)});
      send_beat(w[i]);
    end
    exp_msg++;
    drain("backpressure");

    // Reset mid-message: queued words and partial state vanish.
    set_ready(0);
    send_beat({16'd7, 16'd6});
    for (int i = 0; i < 2; i++) send_beat($urandom);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    exp_msg = 0;
    @(negedge CLK);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_msg_count", 64'(msg_count), 64'd0);
    @(posedge CLK);
    #1;
    ready_mode = 1;
    send_msg(16'd1, 16'd2);
    drain("after_reset");

    ready_mode = 2;
    repeat (40) begin
      int          r;
      logic [15:0] id;
      logic [15:0] len;
      id  = 16'($urandom_range(0, 19));
      r   = $urandom_range(0, 15);
      len = (r == 0) ? 16'd0 :
            (r == 1) ? 16'($urandom_range(65, 70)) :
            (r < 5)  ? 16'd1 : 16'($urandom_range(2, 9));
      send_msg(id, len);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
